// File: rtl/gpio_bank_pkg.sv
// ============================================================================
//  Module : gpio_bank_pkg
//  Purpose: Shared constants for the gpio_bank peripheral. This package holds
//           the register offsets inside one channel window and the address
//           stride between consecutive channel windows.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_bank_pkg;

    localparam logic [2:0] OFF_OUT  = 3'd0;  // output value, rw
    localparam logic [2:0] OFF_DIR  = 3'd1;  // output enable, rw
    localparam logic [2:0] OFF_IN   = 3'd2;  // synchronised pin value, ro
    localparam logic [2:0] OFF_EN   = 3'd3;  // interrupt enable, rw
    localparam logic [2:0] OFF_STAT = 3'd4;  // interrupt status, write-1-to-clear
    localparam logic [2:0] OFF_SET  = 3'd5;  // OUT |= data, wo
    localparam logic [2:0] OFF_CLR  = 3'd6;  // OUT &= ~data, wo
    localparam logic [2:0] OFF_POL  = 3'd7;  // edge polarity, 1 = rising

    localparam int CH_STRIDE = 8;

endpackage

`default_nettype wire

// File: rtl/gpio_channel.sv
// ============================================================================
//  Module : gpio_channel
//  Purpose: One GPIO channel. It holds the register set, the input
//           synchroniser, the edge detector and the interrupt status.
//  Ports  : clk_i, rst_ni      clock, asynchronous active-low reset
//           we_i, off_i        decoded write strobe and register offset
//           wdata_i            write data (channel width)
//           warm_ok_i          edge events are allowed
//           pin_i              raw pin inputs (asynchronous)
//           rdata_o            combinational read value for off_i
//           out_o, oe_o        pin drive value and output enable
//           irq_any_o          OR of (status & enable)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_channel
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH = 31
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [2:0]       off_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             warm_ok_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] oe_o,
    output logic             irq_any_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] stat_clr;
    logic [WIDTH-1:0] edge_ev;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        en_d     = en_q;
        pol_d    = pol_q;
        stat_clr = '0;

        // Rising edge for POL=1 bits and falling edge for POL=0 bits.
        edge_ev = (pol_q & ~prev_q & sync2_q) | (~pol_q & prev_q & ~sync2_q);
        if (!warm_ok_i) begin
            edge_ev = '0;
        end

        if (we_i) begin
            case (off_i)
                OFF_OUT:  out_d    = wdata_i;
                OFF_DIR:  dir_d    = wdata_i;
                OFF_EN:   en_d     = wdata_i;
                OFF_STAT: stat_clr = wdata_i;
                OFF_SET:  out_d    = out_q | wdata_i;
                OFF_CLR:  out_d    = out_q & ~wdata_i;
                OFF_POL:  pol_d    = wdata_i;
                default:  ;  // IN is read-only
            endcase
        end

        // Clear first, then set. A new event wins over a same-cycle W1C.
        stat_d = (stat_q & ~stat_clr) | edge_ev;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            pol_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            pol_q   <= pol_d;
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            OFF_OUT:  rdata_o = out_q;
            OFF_DIR:  rdata_o = dir_q;
            OFF_IN:   rdata_o = sync2_q;
            OFF_EN:   rdata_o = en_q;
            OFF_STAT: rdata_o = stat_q;
            OFF_POL:  rdata_o = pol_q;
            default:  rdata_o = '0;  // SET / CLR read as zero
        endcase
    end

    assign out_o     = out_q;
    assign oe_o      = dir_q;
    assign irq_any_o = |(stat_q & en_q);

endmodule

`default_nettype wire

// File: rtl/gpio_bank.sv
// ============================================================================
//  Module : gpio_bank
//  Purpose: Memory-mapped GPIO bank with NUM_CH channels of WIDTH bits on the
//           CPU IO bus. It provides per-bit direction, synchronised read-back,
//           atomic set/clear and edge interrupts.
//  Ports  : CLK, Reset                    clock, asynchronous active-low reset
//           AddressIO, DataWrite          IO bus address and write data
//           WriteIO, ReadIO               one-cycle access strobes
//           DataRead, ReadValid           registered read data and valid
//           GPIO_In, GPIO_Out, GPIO_OE    pin interface
//           IRQ                           registered level interrupt
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 31,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 40
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [ADDR_W-1:0]       AddressIO,
    input  logic [DATA_W-1:0]       DataWrite,
    input  logic                    WriteIO,
    input  logic                    ReadIO,
    output logic [DATA_W-1:0]       DataRead,
    output logic                    ReadValid,
    input  logic [NUM_CH*WIDTH-1:0] GPIO_In,
    output logic [NUM_CH*WIDTH-1:0] GPIO_Out,
    output logic [NUM_CH*WIDTH-1:0] GPIO_OE,
    output logic                    IRQ
);

    localparam logic [ADDR_W:0] ADDR_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] ADDR_HI = (ADDR_W+1)'(BASE_ADDR + CH_STRIDE*NUM_CH);

    logic              hit;
    logic [ADDR_W-1:0] rel;
    logic [2:0]        off;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] irq_any;
    logic [WIDTH-1:0]  ch_rdata [NUM_CH];
    logic [DATA_W-1:0] rd_ext;
    logic [1:0]        warm_q;
    logic              warm_ok;
    logic [DATA_W-1:0] data_read_q;
    logic              read_valid_q;
    logic              irq_q;

    assign hit     = ({1'b0, AddressIO} >= ADDR_LO) && ({1'b0, AddressIO} < ADDR_HI);
    assign rel     = AddressIO - ADDR_LO[ADDR_W-1:0];
    assign off     = rel[2:0];
    assign warm_ok = (warm_q == 2'd3);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_sel[g] = hit && (rel[ADDR_W-1:3] == (ADDR_W-3)'(g));

        gpio_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk_i     (CLK),
            .rst_ni    (Reset),
            .we_i      (WriteIO && ch_sel[g]),
            .off_i     (off),
            .wdata_i   (DataWrite[WIDTH-1:0]),
            .warm_ok_i (warm_ok),
            .pin_i     (GPIO_In[g*WIDTH +: WIDTH]),
            .rdata_o   (ch_rdata[g]),
            .out_o     (GPIO_Out[g*WIDTH +: WIDTH]),
            .oe_o      (GPIO_OE[g*WIDTH +: WIDTH]),
            .irq_any_o (irq_any[g])
        );
    end

    // Zero-extended read mux. This form also holds for WIDTH == DATA_W.
    always_comb begin
        rd_ext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                rd_ext[WIDTH-1:0] = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            warm_q       <= 2'd0;
            data_read_q  <= '0;
            read_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            // Saturating counter: edge events stay masked for the first three cycles.
            if (!warm_ok) begin
                warm_q <= warm_q + 2'd1;
            end
            read_valid_q <= ReadIO && hit;
            if (ReadIO && hit) begin
                data_read_q <= rd_ext;
            end
            irq_q <= |irq_any;
        end
    end

    assign DataRead  = data_read_q;
    assign ReadValid = read_valid_q;
    assign IRQ       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_bank.sv
// ============================================================================
//  Module : tb_gpio_bank
//  Purpose: Self-checking bench for gpio_bank. It runs directed steps and a
//           randomized phase against a register-level reference model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_bank;

    localparam int N  = 2;
    localparam int W  = 31;
    localparam int NW = N * W;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [8:0]    AddressIO;
    logic [31:0]   DataWrite;
    logic          WriteIO;
    logic          ReadIO;
    logic [31:0]   DataRead;
    logic          ReadValid;
    logic [NW-1:0] GPIO_In;
    logic [NW-1:0] GPIO_Out;
    logic [NW-1:0] GPIO_OE;
    logic          IRQ;

    gpio_bank #(
        .NUM_CH(N), .WIDTH(W), .DATA_W(32), .ADDR_W(9), .BASE_ADDR(40)
    ) dut (
        .CLK(CLK), .Reset(Reset), .AddressIO(AddressIO), .DataWrite(DataWrite),
        .WriteIO(WriteIO), .ReadIO(ReadIO), .DataRead(DataRead),
        .ReadValid(ReadValid), .GPIO_In(GPIO_In), .GPIO_Out(GPIO_Out),
        .GPIO_OE(GPIO_OE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    // Reference model: architectural registers plus pin history.
    // m_hist[0] holds the pin value seen at the previous edge, m_hist[1] the one before it, and so on.
    logic [W-1:0]  m_out [N];
    logic [W-1:0]  m_dir [N];
    logic [W-1:0]  m_en  [N];
    logic [W-1:0]  m_stat[N];
    logic [W-1:0]  m_pol [N];
    logic [NW-1:0] m_hist[3];
    logic [31:0]   m_drd;
    logic          m_rv;
    logic          m_irq;
    int            m_edges;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_reg(input int ch, input int off);
        case (off)
            0: return m_out[ch];
            1: return m_dir[ch];
            2: return m_hist[1][ch*W +: W];
            3: return m_en[ch];
            4: return m_stat[ch];
            7: return m_pol[ch];
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        int a, ch, off;
        logic hit;
        logic [W-1:0] wd, oldp, newp, ev;
        if (!Reset) begin
            for (int c = 0; c < N; c++) begin
                m_out[c] = '0; m_dir[c] = '0; m_en[c] = '0; m_stat[c] = '0; m_pol[c] = '0;
            end
            for (int k = 0; k < 3; k++) m_hist[k] = '0;
            m_drd = '0; m_rv = 1'b0; m_irq = 1'b0; m_edges = 0;
        end else begin
            a   = int'(AddressIO);
            hit = (a >= 40) && (a < 40 + 8 * N);
            ch  = (a - 40) / 8;
            off = (a - 40) % 8;
            wd  = DataWrite[W-1:0];
            m_rv = ReadIO && hit;
            if (ReadIO && hit) m_drd = {1'b0, model_reg(ch, off)};
            m_irq = 1'b0;
            for (int c = 0; c < N; c++) m_irq |= |(m_stat[c] & m_en[c]);
            for (int c = 0; c < N; c++) begin
                oldp = m_hist[2][c*W +: W];
                newp = m_hist[1][c*W +: W];
                ev = (m_edges >= 3) ? ((m_pol[c] & ~oldp & newp) | (~m_pol[c] & oldp & ~newp)) : '0;
                if (WriteIO && hit && ch == c && off == 4) m_stat[c] = m_stat[c] & ~wd;
                m_stat[c] = m_stat[c] | ev;
            end
            if (WriteIO && hit) begin
                case (off)
                    0: m_out[ch] = wd;
                    1: m_dir[ch] = wd;
                    3: m_en[ch]  = wd;
                    5: m_out[ch] = m_out[ch] | wd;
                    6: m_out[ch] = m_out[ch] & ~wd;
                    7: m_pol[ch] = wd;
                    default: ;
                endcase
            end
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = GPIO_In;
            if (m_edges < 3) m_edges++;
        end
        @(posedge CLK);
        #1;
        chk("gpio_out", 64'(GPIO_Out), 64'({m_out[1], m_out[0]}));
        chk("gpio_oe",  64'(GPIO_OE),  64'({m_dir[1], m_dir[0]}));
        chk("irq",      64'(IRQ),      64'(m_irq));
        chk("rvalid",   64'(ReadValid), 64'(m_rv));
        chk("rdata",    64'(DataRead), 64'(m_drd));
        WriteIO = 1'b0;
        ReadIO  = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        AddressIO = 9'(addr); DataWrite = data; WriteIO = 1'b1;
        tick();
    endtask

    task automatic rd(input string tag, input int addr, input logic [31:0] exp);
        AddressIO = 9'(addr); ReadIO = 1'b1;
        tick();
        chk({tag, "_valid"}, 64'(ReadValid), 64'd1);
        chk(tag, 64'(DataRead), 64'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] last_rd;
        Reset = 1'b0; AddressIO = '0; DataWrite = '0; WriteIO = 1'b0; ReadIO = 1'b0;
        GPIO_In = '1;

        // 1: reset with pins high, no status after warm-up
        idle(2);
        chk("reset_out", 64'(GPIO_Out), 64'd0);
        chk("reset_irq", 64'(IRQ), 64'd0);
        Reset = 1'b1;
        idle(10);
        rd("stat0_warm", 44, 32'h0);
        rd("stat1_warm", 52, 32'h0);

        // 2: OUT write and read-back
        GPIO_In = '0;
        wr(40, 32'h0000_00A5);
        chk("out_pin_a5", 64'(GPIO_Out[W-1:0]), 64'h0A5);
        rd("out_a5", 40, 32'h0000_00A5);

        // 3: set / clear / direction
        wr(45, 32'h100);
        rd("out_set", 40, 32'h1A5);
        wr(46, 32'h005);
        rd("out_clr", 40, 32'h1A0);
        wr(41, 32'hFFFF_FFFF);
        chk("oe_all", 64'(GPIO_OE[W-1:0]), 64'h7FFF_FFFF);
        rd("dir_rd", 41, 32'h7FFF_FFFF);
        rd("set_rd0", 45, 32'h0);

        // 4: ch1 rising interrupt on bit 0 (GPIO_In[31])
        idle(4);
        wr(44, 32'hFFFF_FFFF);
        wr(52, 32'hFFFF_FFFF);
        wr(55, 32'h1);
        wr(51, 32'h1);
        GPIO_In[31] = 1'b1;
        idle(2);
        chk("irq_not_early", 64'(IRQ), 64'd0);
        tick();
        rd("stat1_set", 52, 32'h1);
        chk("irq_set", 64'(IRQ), 64'd1);
        wr(52, 32'h1);
        tick();
        chk("irq_clr", 64'(IRQ), 64'd0);

        // 5: W1C collides with a new rising event
        GPIO_In[31] = 1'b0;
        idle(4);
        GPIO_In[31] = 1'b1;
        idle(2);
        wr(52, 32'h1);
        rd("stat1_keep", 52, 32'h1);
        chk("irq_keep", 64'(IRQ), 64'd1);

        // 6: miss accesses and reset mid-write
        last_rd = DataRead;
        AddressIO = 9'd56; ReadIO = 1'b1;
        tick();
        chk("miss_valid", 64'(ReadValid), 64'd0);
        chk("miss_hold", 64'(DataRead), 64'(last_rd));
        wr(39, 32'hFFFF_FFFF);
        rd("miss_wr", 40, 32'h1A0);
        AddressIO = 9'd40; DataWrite = 32'h3FF; WriteIO = 1'b1;
        #2 Reset = 1'b0;
        tick();
        GPIO_In = '1;
        tick();
        Reset = 1'b1;
        wr(47, 32'hFFFF_FFFF);  // rising polarity while warm-up masks events
        idle(8);
        rd("rst_out0", 40, 32'h0);
        rd("rst_dir0", 41, 32'h0);
        rd("rst_en1",  51, 32'h0);
        rd("rst_stat0", 44, 32'h0);
        rd("rst_pol1", 55, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            AddressIO = 9'($urandom_range(36, 60));
            DataWrite = $urandom;
            WriteIO   = ($urandom_range(0, 2) == 0);
            ReadIO    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0)
                GPIO_In = GPIO_In ^ (NW'({$urandom, $urandom}) & NW'({$urandom, $urandom})
                                     & NW'({$urandom, $urandom}));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised, memory-mapped GPIO peripheral that replaces the per-port write-only GPIO registers in the SoC top.
- Serves NUM_CH channels of WIDTH bits on the CPU IO bus (AddressIO / DataOutput / WriteIO).
- Adds per-bit direction, synchronised input read-back, atomic set/clear and edge-triggered interrupts.
- Sits between the CPU IO port and the board pins; the top wires one instance instead of per-port address decode.

Parameters:
NUM_CH, 2, number of channels
WIDTH, 31, bits per channel (1..DATA_W)
DATA_W, 32, IO bus data width
ADDR_W, 9, IO bus address width
BASE_ADDR, 40, IO address of channel 0 offset 0; BASE_ADDR+8*NUM_CH must fit in ADDR_W

Ports:
CLK  in  1  system clock, all logic on posedge
Reset  in  1  asynchronous, active-low reset
AddressIO  in  ADDR_W  IO bus address
DataWrite  in  DATA_W  IO bus write data
WriteIO  in  1  write strobe, one-cycle qualifier
ReadIO  in  1  read strobe, one-cycle qualifier
DataRead  out  DATA_W  read data, registered
ReadValid  out  1  pulses with DataRead on a mapped read
GPIO_In  in  NUM_CH*WIDTH  pin inputs, asynchronous to CLK
GPIO_Out  out  NUM_CH*WIDTH  pin output values
GPIO_OE  out  NUM_CH*WIDTH  pin output enables, 1 = drive
IRQ  out  1  level interrupt, registered

Behaviour:
- Decode: hit when BASE_ADDR <= AddressIO < BASE_ADDR+8*NUM_CH. ch = (AddressIO-BASE_ADDR)/8, off = (AddressIO-BASE_ADDR)%8.
- Offsets: 0 OUT (rw); 1 DIR (rw); 2 IN (ro); 3 IRQ_EN (rw); 4 IRQ_STAT (read, write-1-to-clear); 5 OUT_SET (wo, OUT |= data); 6 OUT_CLR (wo, OUT &= ~data); 7 IRQ_POL (rw, 1 = rising, 0 = falling).
- Writes use DataWrite[WIDTH-1:0] only. Upper bits are ignored. A write to IN, or to any miss address, has no effect.
- Write latency: the register updates on the posedge where WriteIO=1. GPIO_Out and GPIO_OE equal the OUT and DIR registers directly, so the pins change in the cycle after the strobe.
- Reads: on ReadIO=1 with a hit, DataRead = zero-extended register value and ReadValid=1 on the next cycle; ReadValid is 0 otherwise. Reads of OUT_SET and OUT_CLR return 0. A read with a miss gives ReadValid=0 and leaves DataRead unchanged.
- Read and write in the same cycle are legal. The read returns the pre-write value.
- Input path: 2-flop synchroniser per bit, then a previous-value flop. IN reads the second synchroniser stage.
- Edge event when (prev, sync) = (0,1) and POL=1, or (1,0) and POL=0.
- IRQ_STAT bit is set on an event regardless of IRQ_EN. Set has priority over a same-cycle W1C of the same bit. A pin change sets its status bit 3 cycles after the change.
- IRQ = registered OR over all channels of (IRQ_STAT & IRQ_EN). It follows status or enable changes by 1 cycle.
- Warm-up: a 2-bit counter suppresses edge events for the first 3 cycles after Reset deasserts, so pins held at a level across reset create no events. Status writes are accepted during warm-up.
- Reset (Reset=0, asynchronous) clears:
  - OUT, DIR, IRQ_EN, IRQ_STAT, IRQ_POL
  - synchroniser and prev flops, warm-up counter
  - DataRead, ReadValid, IRQ, GPIO_Out, GPIO_OE, all to 0
- A reset mid-transaction discards the access. No partial update is allowed.

Decomposition:
- Package gpio_bank_pkg holds the offset constants (OFF_OUT=0 .. OFF_POL=7) and CH_STRIDE=8.
- Sub-module gpio_channel: one channel's registers, synchroniser, edge detect and status logic, with inputs we/off/wdata/warm_ok and outputs rdata/irq_any. The top instantiates NUM_CH copies and owns the decode, the read mux, IRQ and the warm-up counter.

Test Plan:
1. Reset low for 2 cycles, then release with GPIO_In=all 1s -> all outputs 0 and no IRQ_STAT bits set after 10 cycles (warm-up suppression).
2. Write addr 40 data 0x000000A5, then read addr 40 -> GPIO_Out[30:0]=0xA5 the cycle after the write; DataRead=0x000000A5 with ReadValid=1 one cycle after ReadIO.
3. OUT_SET addr 45 data 0x100, then OUT_CLR addr 46 data 0x005 -> OUT reads 0x1A5, then 0x1A0. Write addr 41 data 0xFFFFFFFF -> GPIO_OE[30:0]=0x7FFFFFFF.
4. Ch1: write 0x1 to addr 55 (POL) and addr 51 (EN), then drive GPIO_In[31] 0->1 -> addr 52 reads 0x1 after 3 cycles and IRQ=1 one cycle later. W1C addr 52 data 0x1 -> IRQ=0 next cycle.
5. Apply a W1C of bit0 on the same cycle a new rising event on that bit is detected -> IRQ_STAT bit0 stays 1 and IRQ stays 1.
6. Read addr 56 (miss) and write addr 39 -> ReadValid=0 and no register changes. Assert Reset mid-write -> all registers read 0 after release.
